// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter that raises an interrupt for CP0.
// Latency: register writes take effect at the next rising edge; readData is combinational.
// Backpressure: none; writes are accepted every cycle and override the counting sequence.
module timer_counter #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        writeEnable,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  state_t                   state;
  logic                     ctrl_en;
  logic [1:0]               ctrl_mode;
  logic                     ctrl_im;
  logic [COUNTER_WIDTH-1:0] preset;
  logic [COUNTER_WIDTH-1:0] count;
  logic                     irq_pending;

  logic ctrl_wr;
  logic preset_wr;
  logic auto_reload;

  assign ctrl_wr     = writeEnable && (address == ADDR_CTRL);
  assign preset_wr   = writeEnable && (address == ADDR_PRESET);
  // Only mode 1 reloads; modes 0, 2 and 3 all behave as one-shot.
  assign auto_reload = (ctrl_mode == 2'd1);

  // The mask only gates the request; it never creates a pending interrupt.
  assign irq = irq_pending & ctrl_im;

  // Register file and counting FSM; software writes win over any state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ctrl_en     <= 1'b0;
      ctrl_mode   <= 2'd0;
      ctrl_im     <= 1'b0;
      preset      <= '0;
      count       <= '0;
      irq_pending <= 1'b0;
    end else if (ctrl_wr || preset_wr) begin
      if (ctrl_wr) begin
        ctrl_en   <= writeData[0];
        ctrl_mode <= writeData[2:1];
        ctrl_im   <= writeData[3];
      end
      if (preset_wr) begin
        preset <= writeData[COUNTER_WIDTH-1:0];
      end
      // A reconfiguration acknowledges any pending interrupt and restarts
      // the sequence from IDLE; COUNT keeps its value until the next LOAD.
      state       <= IDLE;
      irq_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count > ONE) begin
            count <= count - ONE;
          end else begin
            // COUNT of 0 or 1 expires; saturate at zero rather than wrap.
            count       <= '0;
            irq_pending <= 1'b1;
            state       <= INT;
            if (!auto_reload) begin
              ctrl_en <= 1'b0;
            end
          end
        end
        INT: begin
          // One-shot parks here until software writes; auto-reload
          // drops the request after one cycle and reloads.
          if (auto_reload) begin
            irq_pending <= 1'b0;
            state       <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational read mux; narrow counters are zero-extended to 32 bits.
  always_comb begin
    readData = 32'd0;
    case (address)
      ADDR_CTRL:   readData[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: readData[COUNTER_WIDTH-1:0] = preset;
      ADDR_COUNT:  readData[COUNTER_WIDTH-1:0] = count;
      default:     readData = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: table-driven vectors plus
// hand-written multi-cycle sequences (reset, hold, auto-reload, collision).
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  timer_counter #(.COUNTER_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .writeEnable(writeEnable),
    .writeData  (writeData),
    .readData   (readData),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [1:0] wa, input logic we, input logic [31:0] wd,
                     input logic [1:0] ra, input logic [31:0] er, input logic ei);
    vec_t v;
    v.waddr = wa; v.we = we; v.wdata = wd;
    v.raddr = ra; v.exp_rd = er; v.exp_irq = ei;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writeData = d; writeEnable = 1'b1;
    tick();
    writeEnable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readData;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    logic [31:0] v;
    for (int i = lo; i <= hi; i++) begin
      address = vt[i].waddr; writeData = vt[i].wdata; writeEnable = vt[i].we;
      tick();
      writeEnable = 1'b0;
      rd(vt[i].raddr, v);
      check($sformatf("row%0d_rd", i), v, vt[i].exp_rd);
      check($sformatf("row%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
    end
  endtask

  initial begin
    logic [31:0] v;
    int ack_lo;

    // One-shot: PRESET=3, CTRL=0x9 at T0; COUNT 3,2,1,0 after T2..T5.
    add(2'd1, 1'b1, 32'd3,   2'd1, 32'd3, 1'b0); // PRESET write
    add(2'd0, 1'b1, 32'h9,   2'd2, 32'd0, 1'b0); // T0
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd0, 1'b0); // T1 LOAD
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd3, 1'b0); // T2
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd2, 1'b0); // T3
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd1, 1'b0); // T4
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd0, 1'b1); // T5 INT
    add(2'd0, 1'b0, 32'd0,   2'd0, 32'h8, 1'b1); // En cleared
    ack_lo = vt.size();
    // Acknowledge with CTRL=0x8.
    add(2'd0, 1'b1, 32'h8,   2'd2, 32'd0, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd0, 32'h8, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd0, 1'b0);
    // IM=0 one-shot: irq masked, COUNT still reaches 0.
    add(2'd0, 1'b1, 32'h1,   2'd2, 32'd0, 1'b0); // U0
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd0, 1'b0); // U1 LOAD
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd3, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd2, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd1, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd2, 32'd0, 1'b0); // INT, masked
    add(2'd0, 1'b0, 32'd0,   2'd0, 32'h0, 1'b0);
    // Writes to COUNT and address 3 are ignored.
    add(2'd2, 1'b1, 32'h55,  2'd2, 32'd0, 1'b0);
    add(2'd3, 1'b1, 32'hFFFF_FFFF, 2'd3, 32'd0, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd0, 32'd0, 1'b0);
    add(2'd0, 1'b0, 32'd0,   2'd1, 32'd3, 1'b0);

    // Reset state.
    reset = 1'b1; address = 2'd0; writeEnable = 1'b0; writeData = 32'd0;
    tick(); tick();
    rd(2'd0, v); check("por_ctrl", v, 32'd0);
    rd(2'd1, v); check("por_preset", v, 32'd0);
    rd(2'd2, v); check("por_count", v, 32'd0);
    check("por_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick();

    // Reset asserted mid-count.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB);
    for (int k = 0; k < 5; k++) tick();
    rd(2'd2, v); check("midcount_count", v, 32'd7);
    reset = 1'b1;
    #1;
    rd(2'd0, v); check("rst_ctrl", v, 32'd0);
    rd(2'd1, v); check("rst_preset", v, 32'd0);
    rd(2'd2, v); check("rst_count", v, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rd(2'd2, v); check($sformatf("post_rst_count%0d", k), v, 32'd0);
      check($sformatf("post_rst_irq%0d", k), {31'd0, irq}, 32'd0);
    end

    // One-shot, then hold irq for 20 cycles, then acknowledge and IM=0.
    apply_rows(0, ack_lo - 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("hold_irq%0d", k), {31'd0, irq}, 32'd1);
    end
    apply_rows(ack_lo, vt.size() - 1);

    // Auto-reload PRESET=2: pulses every 4 cycles.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      logic [31:0] ec;
      tick();
      if (k == 1) ec = 32'd0;
      else case ((k - 2) % 4)
        0: ec = 32'd2;
        1: ec = 32'd1;
        default: ec = 32'd0;
      endcase
      rd(2'd2, v); check($sformatf("ar2_count%0d", k), v, ec);
      check($sformatf("ar2_irq%0d", k), {31'd0, irq}, {31'd0, (k >= 4) && (k % 4 == 0)});
    end
    rd(2'd0, v); check("ar2_ctrl", v, 32'hB);

    // Auto-reload PRESET=1: period 3.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("ar1_irq%0d", k), {31'd0, irq}, {31'd0, (k % 3 == 0)});
    end

    // One-shot PRESET=0: INT after 3 cycles.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("p0_irq%0d", k), {31'd0, irq}, {31'd0, (k >= 3)});
    end

    // Collision: PRESET write on the edge where COUNT=1 would expire.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 0; k < 4; k++) tick();
    rd(2'd2, v); check("col_pre_count", v, 32'd1);
    wr(2'd1, 32'd5);
    rd(2'd2, v); check("col_c5_count", v, 32'd1);
    check("col_c5_irq", {31'd0, irq}, 32'd0);
    tick();
    rd(2'd2, v); check("col_c6_count", v, 32'd1);
    check("col_c6_irq", {31'd0, irq}, 32'd0);
    tick();
    rd(2'd2, v); check("col_c7_count", v, 32'd5);
    tick();
    rd(2'd2, v); check("col_c8_count", v, 32'd4);
    check("col_c8_irq", {31'd0, irq}, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    rd(2'd2, v); check("col_end_count", v, 32'd0);
    check("col_end_irq", {31'd0, irq}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
